// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage 16-bit core: stage enables/flushes,
// EX-stage forwarding selects, data-memory wait sequencing and a stall counter.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] ifid_rs1,
   input  logic [2:0] ifid_rs2,
   input  logic       ifid_use_rs1,
   input  logic       ifid_use_rs2,
   input  logic [2:0] idex_rs1,
   input  logic [2:0] idex_rs2,
   input  logic [2:0] idex_rd,
   input  logic       idex_MemRead,
   input  logic [2:0] exmem_rd,
   input  logic       exmem_RegWrite,
   input  logic       exmem_MemRead,
   input  logic       exmem_MemWrite,
   input  logic [2:0] memwb_rd,
   input  logic       memwb_RegWrite,
   input  logic       branch_taken,
   input  logic       jump_id,
   input  logic       dmem_ready,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic       memwb_flush,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       dmem_req,
   output logic       dmem_err,
   output logic [15:0] stall_cycles,
   output logic [1:0] fsm_state
);

   // Memory handshake: dmem_req stays high while the MEM-stage access is
   // outstanding; the access completes in the cycle dmem_ready is seen high
   // together with dmem_req. Dropping req without ready means abort.
   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       err_set;
   logic       memop;
   logic       load_use;
   logic       ex_ok, wb_ok;
   logic       rel_pc_en, rel_ifid_en, rel_ifid_flush, rel_idex_flush;

   assign fsm_state = state;
   assign memop     = exmem_MemRead | exmem_MemWrite;
   assign ex_ok     = exmem_RegWrite && !exmem_MemRead && (exmem_rd != 3'd0);
   assign wb_ok     = memwb_RegWrite && (memwb_rd != 3'd0);
   assign load_use  = idex_MemRead && (idex_rd != 3'd0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

   // Control-flow strobes used whenever the pipe is not frozen by memory.
   always_comb begin
      rel_pc_en      = 1'b1;
      rel_ifid_en    = 1'b1;
      rel_ifid_flush = 1'b0;
      rel_idex_flush = 1'b0;
      if (branch_taken) begin
         rel_ifid_flush = 1'b1;
         rel_idex_flush = 1'b1;
      end else if (load_use) begin
         rel_pc_en      = 1'b0;
         rel_ifid_en    = 1'b0;
         rel_idex_flush = 1'b1;
      end else if (jump_id) begin
         rel_ifid_flush = 1'b1;
      end
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (state == RUN || state == MEM_WAIT) begin
         if (ex_ok && exmem_rd == idex_rs1)      fwd_a = 2'b10;
         else if (wb_ok && memwb_rd == idex_rs1) fwd_a = 2'b01;
         if (ex_ok && exmem_rd == idex_rs2)      fwd_b = 2'b10;
         else if (wb_ok && memwb_rd == idex_rs2) fwd_b = 2'b01;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      err_set      = 1'b0;
      dmem_req     = 1'b0;
      pc_en        = rel_pc_en;
      ifid_en      = rel_ifid_en;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = rel_ifid_flush;
      idex_flush   = rel_idex_flush;
      exmem_flush  = 1'b0;
      memwb_flush  = 1'b0;
      case (state)
         RUN: begin
            dmem_req = memop;
            if (memop && !dmem_ready) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == TIMEOUT_CNT) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
               err_set      = 1'b1;
               exmem_flush  = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_flush  = 1'b1;
         end
      endcase

      // Memory freeze: only WB drains, receiving a bubble.
      if ((state == RUN && memop && !dmem_ready) ||
          (state == MEM_WAIT && !dmem_ready)) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b1;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         memwb_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= INIT;
         wait_cnt     <= 8'd0;
         dmem_err     <= 1'b0;
         stall_cycles <= 16'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (err_set) dmem_err <= 1'b1;
         if ((state == RUN || state == MEM_WAIT) && !pc_en && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl, checked every cycle
// against a cycle-level behavioural model of the controller rules.
module tb_pipe_hazard_ctrl;

   localparam int TMO    = 4;
   localparam int M_INIT = 0;
   localparam int M_RUN  = 1;
   localparam int M_WAIT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
   logic       ifid_use_rs1, ifid_use_rs2, idex_MemRead;
   logic       exmem_RegWrite, exmem_MemRead, exmem_MemWrite, memwb_RegWrite;
   logic       branch_taken, jump_id, dmem_ready;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [1:0] fwd_a, fwd_b, fsm_state;
   logic       dmem_req, dmem_err;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_pass   = 0;

   // model state (current and next)
   int m_mode = M_INIT, m_waited = 0, m_stalls = 0;
   bit m_err = 0;
   int n_mode, n_waited, n_stalls;
   bit n_err;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_MemRead(idex_MemRead),
      .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite),
      .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
      .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite),
      .branch_taken(branch_taken), .jump_id(jump_id), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .dmem_req(dmem_req), .dmem_err(dmem_err),
      .stall_cycles(stall_cycles), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [1:0] fwd_of(input logic [2:0] rs);
      if (exmem_RegWrite && !exmem_MemRead && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
      if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Evaluates the model for the current inputs, optionally compares all outputs.
   task automatic model_eval(input bit do_check);
      bit e_pc, e_ifid, e_idex, e_exmem, e_memwb;
      bit f_ifid, f_idex, f_exmem, f_memwb, e_req, frozen, lu, memop;
      logic [1:0] e_fa, e_fb;
      if (rst) begin
         m_mode = M_INIT; m_waited = 0; m_err = 0; m_stalls = 0;
      end
      memop = exmem_MemRead || exmem_MemWrite;
      lu = idex_MemRead && idex_rd != 0 &&
           ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
      n_mode = m_mode; n_waited = m_waited; n_err = m_err;
      {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
      {f_ifid, f_idex, f_exmem, f_memwb} = 4'b0000;
      e_req = 0; e_fa = 2'b00; e_fb = 2'b00; frozen = 0;
      if (m_mode == M_INIT) begin
         {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
         {f_ifid, f_idex, f_exmem, f_memwb} = 4'b1111;
         n_mode = M_RUN;
      end else begin
         e_fa = fwd_of(idex_rs1);
         e_fb = fwd_of(idex_rs2);
         if (m_mode == M_RUN) begin
            e_req = memop;
            if (memop && !dmem_ready) begin
               frozen = 1; n_mode = M_WAIT; n_waited = 1;
            end
         end else begin
            e_req = 1;
            if (dmem_ready) n_mode = M_RUN;
            else begin
               frozen = 1;
               if (m_waited == TMO) begin
                  f_exmem = 1; n_err = 1; n_mode = M_RUN;
               end else n_waited = m_waited + 1;
            end
         end
         if (frozen) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            f_memwb = 1;
         end else if (branch_taken) begin
            f_ifid = 1; f_idex = 1;
         end else if (lu) begin
            e_pc = 0; e_ifid = 0; f_idex = 1;
         end else if (jump_id) begin
            f_ifid = 1;
         end
      end
      n_stalls = (m_mode != M_INIT && !e_pc && m_stalls < 65535) ? m_stalls + 1 : m_stalls;
      if (do_check) begin
         check_eq("pc_en", pc_en, e_pc);
         check_eq("ifid_en", ifid_en, e_ifid);
         check_eq("idex_en", idex_en, e_idex);
         check_eq("exmem_en", exmem_en, e_exmem);
         check_eq("memwb_en", memwb_en, e_memwb);
         check_eq("ifid_flush", ifid_flush, f_ifid);
         check_eq("idex_flush", idex_flush, f_idex);
         check_eq("exmem_flush", exmem_flush, f_exmem);
         check_eq("memwb_flush", memwb_flush, f_memwb);
         check_eq("fwd_a", fwd_a, e_fa);
         check_eq("fwd_b", fwd_b, e_fb);
         check_eq("dmem_req", dmem_req, e_req);
         check_eq("dmem_err", dmem_err, m_err);
         check_eq("stall_cycles", stall_cycles, m_stalls);
         check_eq("fsm_state", fsm_state, m_mode);
      end
   endtask

   task automatic run_cycle(input bit do_check);
      @(negedge clk);
      model_eval(do_check);
      @(posedge clk);
      if (rst) begin
         m_mode = M_INIT; m_waited = 0; m_err = 0; m_stalls = 0;
      end else begin
         m_mode = n_mode; m_waited = n_waited; m_err = n_err; m_stalls = n_stalls;
      end
      #1;
   endtask

   // driver tasks
   task automatic drive_idle();
      ifid_rs1 = 3'd1; ifid_rs2 = 3'd2; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
      idex_rs1 = 3'd0; idex_rs2 = 3'd0; idex_rd = 3'd0; idex_MemRead = 0;
      exmem_rd = 3'd0; exmem_RegWrite = 0; exmem_MemRead = 0; exmem_MemWrite = 0;
      memwb_rd = 3'd0; memwb_RegWrite = 0;
      branch_taken = 0; jump_id = 0; dmem_ready = 0;
   endtask

   task automatic drive_random();
      ifid_rs1 = 3'($urandom_range(0, 3)); ifid_rs2 = 3'($urandom_range(0, 3));
      ifid_use_rs1 = 1'($urandom_range(0, 1)); ifid_use_rs2 = 1'($urandom_range(0, 1));
      idex_rs1 = 3'($urandom_range(0, 3)); idex_rs2 = 3'($urandom_range(0, 3));
      idex_rd = 3'($urandom_range(0, 3));
      idex_MemRead = ($urandom_range(0, 99) < 30);
      exmem_rd = 3'($urandom_range(0, 3)); exmem_RegWrite = 1'($urandom_range(0, 1));
      exmem_MemRead = ($urandom_range(0, 99) < 15);
      exmem_MemWrite = ($urandom_range(0, 99) < 10);
      memwb_rd = 3'($urandom_range(0, 3)); memwb_RegWrite = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 99) < 10);
      jump_id = ($urandom_range(0, 99) < 10);
      dmem_ready = ($urandom_range(0, 99) < 40);
      rst = ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      // reset held 3 cycles, then one INIT cycle and RUN
      repeat (3) run_cycle(1);
      rst = 1'b0;
      run_cycle(1);
      run_cycle(1);
      check_eq("run_pc_en", pc_en, 1);
      check_eq("run_stall0", stall_cycles, 0);

      // forwarding priority
      exmem_rd = 3'd3; exmem_RegWrite = 1; memwb_rd = 3'd3; memwb_RegWrite = 1;
      idex_rs1 = 3'd3; idex_rs2 = 3'd0;
      #1 check_eq("fwd_a_exmem", fwd_a, 2'b10);
      check_eq("fwd_b_zero", fwd_b, 2'b00);
      run_cycle(1);
      exmem_RegWrite = 0;
      #1 check_eq("fwd_a_memwb", fwd_a, 2'b01);
      run_cycle(1);
      drive_idle();

      // load-use: one bubble, then with branch taken
      idex_MemRead = 1; idex_rd = 3'd5; ifid_rs2 = 3'd5; ifid_use_rs2 = 1;
      run_cycle(1);
      drive_idle();
      run_cycle(1);
      check_eq("lu_stall1", stall_cycles, 1);
      idex_MemRead = 1; idex_rd = 3'd5; ifid_rs2 = 3'd5; ifid_use_rs2 = 1; branch_taken = 1;
      run_cycle(1);
      drive_idle();
      check_eq("br_nostall", stall_cycles, 1);

      // 3-wait load
      exmem_MemRead = 1;
      repeat (3) run_cycle(1);
      dmem_ready = 1;
      run_cycle(1);
      drive_idle();
      run_cycle(1);
      check_eq("wait_stall4", stall_cycles, 4);

      // timeout: RUN detection + TMO wait cycles
      exmem_MemRead = 1;
      repeat (TMO + 1) run_cycle(1);
      drive_idle();
      check_eq("tmo_err", dmem_err, 1);
      repeat (5) run_cycle(1);
      check_eq("err_sticky", dmem_err, 1);

      // reset in MEM_WAIT aborts without error
      exmem_MemWrite = 1;
      repeat (2) run_cycle(1);
      rst = 1;
      run_cycle(1);
      check_eq("rst_abort_err", dmem_err, 0);
      rst = 0;
      drive_idle();
      run_cycle(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         run_cycle(1);
      end
      rst = 0;
      drive_idle();
      repeat (3) run_cycle(1);

      // saturation: persistent load-use stall
      idex_MemRead = 1; idex_rd = 3'd5; ifid_rs1 = 3'd5; ifid_use_rs1 = 1;
      for (int i = 0; i < 70000; i++) begin
         run_cycle(i % 4096 == 0);
      end
      check_eq("sat_model", stall_cycles, m_stalls);
      check_eq("sat_ffff", stall_cycles, 16'hFFFF);
      drive_idle();
      run_cycle(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 16-bit, 5-stage RISC core with eight 3-bit-addressed registers. It generates the enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, and the EX-stage forwarding selects. It also sequences multi-cycle data-memory accesses through a req/ready handshake with timeout, and keeps a saturating stall counter. It sits beside the datapath and reads only pipeline-register fields.

## Interface
- MEM_TIMEOUT, 8: maximum MEM_WAIT cycles before abort (1..255)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ifid_rs1, ifid_rs2  in  3 each  source regs of instruction in ID
- ifid_use_rs1, ifid_use_rs2  in  1 each  ID instruction actually reads that source
- idex_rs1, idex_rs2  in  3 each  source regs of instruction in EX
- idex_rd  in  3  dest reg in EX
- idex_MemRead  in  1  EX instruction is a load
- exmem_rd  in  3  dest reg in MEM
- exmem_RegWrite, exmem_MemRead, exmem_MemWrite  in  1 each  MEM-stage controls
- memwb_rd  in  3  dest reg in WB
- memwb_RegWrite  in  1  WB-stage write enable
- branch_taken  in  1  taken branch resolved in EX
- jump_id  in  1  unconditional jump decoded in ID
- dmem_ready  in  1  data memory completes the current access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage hold when 0
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (controls cleared)
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 reg file, 01 MEM/WB, 10 EX/MEM
- dmem_req  out  1  data-memory access request
- dmem_err  out  1  sticky timeout error
- stall_cycles  out  16  saturating count of cycles with pc_en=0

## Operation
- States: INIT, RUN, MEM_WAIT. rst forces INIT. INIT→RUN unconditionally after one clock.
- INIT: all enables 0, all flushes 1, fwd_a=fwd_b=00, dmem_req=0.
- R0 is hardwired zero. A rd of 0 never matches for forwarding or hazards.
- Forwarding (RUN and MEM_WAIT), shown for fwd_a/idex_rs1; fwd_b/idex_rs2 identical:
  - 10 if exmem_RegWrite && !exmem_MemRead && exmem_rd!=0 && exmem_rd==idex_rs1.
  - Else 01 if memwb_RegWrite && memwb_rd!=0 && memwb_rd==idex_rs1.
  - Else 00. EX/MEM has priority over MEM/WB (newer value).
- memop = exmem_MemRead | exmem_MemWrite. In RUN, dmem_req = memop. In MEM_WAIT, dmem_req = 1.
- Priority in RUN, highest first:
  1. Memory stall: memop && !dmem_ready → next state MEM_WAIT. pc_en, ifid_en, idex_en, exmem_en = 0. memwb_en=1 with memwb_flush=1. No other flush.
  2. branch_taken → pc_en=1, ifid_flush=1, idex_flush=1. Overrides jump_id and load-use.
  3. Load-use: idex_MemRead && idex_rd!=0 && ((ifid_use_rs1 && ifid_rs1==idex_rd) || (ifid_use_rs2 && ifid_rs2==idex_rd)) → pc_en=0, ifid_en=0, idex_flush=1.
  4. jump_id → ifid_flush=1, pc_en=1.
  5. Otherwise all enables 1, all flushes 0.
- MEM_WAIT:
  - Same freeze as rule 1. branch_taken, jump_id and load-use are ignored (their sources are frozen).
  - dmem_ready → RUN. This is the release cycle: all enables 1, and rules 2–5 are evaluated normally.
  - Wait counter reaching MEM_TIMEOUT without ready → set dmem_err, pulse exmem_flush and memwb_flush, → RUN.
- dmem_err clears only on rst.
- stall_cycles increments on every RUN/MEM_WAIT cycle with pc_en=0 and saturates at 0xFFFF. INIT cycles are not counted.

## Timing
- Forwarding and all strobes are combinational from state plus inputs. State, wait counter, dmem_err and stall_cycles are registered.
- Reset values: state INIT, wait counter 0, dmem_err 0, stall_cycles 0. During rst: all enables 0, all flushes 1, fwd 00, dmem_req 0.
- Load-use costs exactly 1 bubble. The consumer then takes fwd=01 from MEM/WB.
- Branch costs 2 bubbles. Jump costs 1 bubble.
- A zero-wait access (ready in the same cycle as req) costs 0 stall cycles. An N-wait access costs N stall cycles.
- The wait counter starts at 1 on the first MEM_WAIT cycle. Timeout fires on the cycle the counter equals MEM_TIMEOUT.
- rst asserted in MEM_WAIT aborts immediately. dmem_req drops asynchronously and dmem_err is not set.

## Test plan
- Reset release: hold rst 3 cycles, release → one INIT cycle (flushes 1, enables 0), then RUN with all enables 1 and stall_cycles=0.
- Forwarding: exmem_rd=3 (RegWrite=1) and memwb_rd=3 (RegWrite=1), idex_rs1=3, idex_rs2=0 → fwd_a=10, fwd_b=00. Clear exmem_RegWrite → fwd_a=01.
- Load-use: idex_MemRead=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1. Same with branch_taken=1 → flush only, no stall.
- Memory waits: exmem_MemRead=1, dmem_ready low 3 cycles → 3 cycles MEM_WAIT freeze with memwb_flush=1; release on ready; stall_cycles+=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready never asserted → dmem_err=1 after 4 wait cycles, exmem_flush pulse, RUN resumes; dmem_err stays 1 until rst.
- Saturation: force 70000 stall cycles → stall_cycles holds 0xFFFF.
